i2c_txn_sequencer: RTL and testbench

//  Shares the single-byte I2C master engine between NREQ on-chip requesters and sequences

---
 rtl/i2c_txn_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_txn_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: round-robin arbiter and transaction sequencer that shares
// one single-byte I2C master engine between NREQ on-chip requesters.
module i2c_txn_sequencer #(
    parameter int NREQ      = 2,
    parameter int TIMEOUT   = 64,
    parameter int DRAIN_CYC = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     req_mode,
    input  logic [7*NREQ-1:0]   req_addr,
    input  logic [8*NREQ-1:0]   req_wdata,
    output logic [NREQ-1:0]     gnt,
    output logic                done,
    output logic                err,
    output logic [7:0]          rdata,
    output logic                m_reset,
    output logic                m_en,
    output logic                m_start,
    output logic                m_stop,
    output logic                m_mode,
    output logic [6:0]          m_address,
    output logic [7:0]          m_register,
    input  logic                m_ack,
    input  logic [7:0]          m_out
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] DRAIN_LAST = TW'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        WAIT_ACK,
        DRAIN,
        FINISH
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            mode_q, mode_d;
    logic [6:0]      addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      ack_cnt_q, ack_cnt_d;
    logic            m_ack_q;

    logic            any_req;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   cand;
    logic            ack_edge;
    logic [TW-1:0]   timer_inc;

    logic [6:0]      addr_arr  [NREQ];
    logic [7:0]      wdata_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_addr[7*g +: 7];
        assign wdata_arr[g] = req_wdata[8*g +: 8];
    end

    assign ack_edge  = m_ack & ~m_ack_q;
    // The timer saturates so a stuck count can never wrap back into range.
    assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

    // Round-robin search: first requesting index after the last granted one.
    always_comb begin
        any_req = 1'b0;
        pick    = ptr_q;
        cand    = ptr_q;
        for (int i = 1; i <= NREQ; i++) begin
            cand = PW'((int'(ptr_q) + i) % NREQ);
            if (!any_req && req[cand]) begin
                any_req = 1'b1;
                pick    = cand;
            end
        end
    end

    // State and datapath registers; reset mid-transaction simply abandons it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= PW'(NREQ - 1);
            mode_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timer_q   <= '0;
            ack_cnt_q <= '0;
            m_ack_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            timer_q   <= timer_d;
            ack_cnt_q <= ack_cnt_d;
            m_ack_q   <= m_ack;
        end
    end

    // Next-state logic: grant, arm, start, count ack edges, drain, finish.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        timer_d   = timer_q;
        ack_cnt_d = ack_cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    ptr_d       = pick;
                    mode_d      = req_mode[pick];
                    addr_d      = addr_arr[pick];
                    wdata_d     = wdata_arr[pick];
                    err_d       = 1'b0;
                    state_d     = ARM;
                end
            end
            ARM: begin
                state_d = START;
            end
            START: begin
                timer_d   = '0;
                ack_cnt_d = '0;
                err_d     = 1'b0;
                state_d   = WAIT_ACK;
            end
            WAIT_ACK: begin
                // An ack edge wins over a timeout landing in the same cycle.
                if (ack_edge) begin
                    timer_d   = '0;
                    ack_cnt_d = ack_cnt_q + 2'd1;
                    if (ack_cnt_q == 2'd1) begin
                        state_d = DRAIN;
                    end
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TMO_LAST) begin
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            DRAIN: begin
                // The timer is reused to count the drain cycles after the last ack.
                timer_d = timer_inc;
                if (timer_q == DRAIN_LAST) begin
                    if (mode_q) begin
                        rdata_d = m_out;
                    end
                    err_d   = 1'b0;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Engine control pins and handshake outputs decoded from the current state.
    always_comb begin
        m_reset    = (state_q != IDLE);
        m_en       = (state_q == START) || (state_q == WAIT_ACK) || (state_q == DRAIN);
        m_start    = (state_q == START);
        m_stop     = mode_q && m_en;
        done       = (state_q == FINISH);
        err        = (state_q == FINISH) && err_q;
        gnt        = gnt_q;
        rdata      = rdata_q;
        m_mode     = mode_q;
        m_address  = addr_q;
        m_register = wdata_q;
    end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: directed tests for i2c_txn_sequencer with the engine's
// ack pulses and read byte driven by hand from the bench.
module tb_i2c_txn_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [1:0]  req_mode;
    logic [13:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  gnt;
    logic        done;
    logic        err;
    logic [7:0]  rdata;
    logic        m_reset;
    logic        m_en;
    logic        m_start;
    logic        m_stop;
    logic        m_mode;
    logic [6:0]  m_address;
    logic [7:0]  m_register;
    logic        m_ack;
    logic [7:0]  m_out;

    int checks = 0;
    int errors = 0;

    i2c_txn_sequencer #(
        .NREQ      (2),
        .TIMEOUT   (64),
        .DRAIN_CYC (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_mode   (req_mode),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .rdata      (rdata),
        .m_reset    (m_reset),
        .m_en       (m_en),
        .m_start    (m_start),
        .m_stop     (m_stop),
        .m_mode     (m_mode),
        .m_address  (m_address),
        .m_register (m_register),
        .m_ack      (m_ack),
        .m_out      (m_out)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Watchdog so a hung sequence still ends the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n clean ack pulses, one cycle high each with a low cycle in between
    task automatic pulse_acks(input int n);
        for (int i = 0; i < n; i++) begin
            m_ack = 1'b1;
            tick();
            m_ack = 1'b0;
            if (i < n - 1) tick();
        end
    endtask

    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (!done && n < limit) begin
            tick();
            n++;
        end
    endtask

    // Full transaction starting from an IDLE cycle with req already visible;
    // returns in the FINISH cycle
    task automatic run_txn(input logic [1:0] exp_gnt, input logic exp_read,
                           input logic [6:0] exp_addr, input logic [7:0] exp_wdata,
                           input logic [7:0] exp_rdata, input logic drop_req,
                           input string name);
        int n;
        tick();
        checks++;
        if (gnt !== exp_gnt) begin
            errors++;
            $display("[TB] FAIL %s_gnt: got %b expected %b", name, gnt, exp_gnt);
        end
        checks++;
        if ({m_reset, m_start, m_mode, m_address, m_register} !== {1'b1, 1'b0, exp_read, exp_addr, exp_wdata}) begin
            errors++;
            $display("[TB] FAIL %s_arm: got rst=%b start=%b mode=%b addr=%h wdata=%h expected rst=1 start=0 mode=%b addr=%h wdata=%h",
                     name, m_reset, m_start, m_mode, m_address, m_register, exp_read, exp_addr, exp_wdata);
        end
        if (drop_req) req = 2'b00;
        tick();
        checks++;
        if ({m_en, m_start, m_stop} !== {1'b1, 1'b1, exp_read}) begin
            errors++;
            $display("[TB] FAIL %s_start: got en/start/stop=%b%b%b expected 11%b",
                     name, m_en, m_start, m_stop, exp_read);
        end
        tick();
        checks++;
        if ({m_en, m_start} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL %s_start_width: got en/start=%b%b expected 10", name, m_en, m_start);
        end
        pulse_acks(2);
        wait_done(20, n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("[TB] FAIL %s_drain_len: got %0d expected 4", name, n);
        end
        checks++;
        if ({done, err, gnt} !== {1'b1, 1'b0, exp_gnt}) begin
            errors++;
            $display("[TB] FAIL %s_done: got done/err/gnt=%b/%b/%b expected 1/0/%b",
                     name, done, err, gnt, exp_gnt);
        end
        if (exp_read) begin
            checks++;
            if (rdata !== exp_rdata) begin
                errors++;
                $display("[TB] FAIL %s_rdata: got %h expected %h", name, rdata, exp_rdata);
            end
        end
    endtask

    // One cycle after done the block is back in IDLE with the engine held in reset
    task automatic check_idle(input string name);
        checks++;
        if ({done, gnt, m_reset, m_en} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL %s_idle: got done=%b gnt=%b m_reset=%b m_en=%b expected all 0",
                     name, done, gnt, m_reset, m_en);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++;
        if ({gnt, done, err, rdata, m_reset, m_en, m_start, m_stop, m_mode, m_address, m_register} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected 00000000",
                     {gnt, done, err, rdata, m_reset, m_en, m_start, m_stop, m_mode, m_address, m_register});
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        check_idle("reset");
    endtask

    task automatic test_write();
        req_mode  = 2'b00;
        req_addr  = {7'h00, 7'h48};
        req_wdata = {8'h00, 8'hA5};
        req       = 2'b01;
        run_txn(2'b01, 1'b0, 7'h48, 8'hA5, 8'h00, 1'b0, "write");
        req = 2'b00;
        tick();
        check_idle("write");
    endtask

    task automatic test_read();
        req_mode  = 2'b10;
        req_addr  = {7'h50, 7'h00};
        req_wdata = {8'h77, 8'h00};
        m_out     = 8'h3C;
        req       = 2'b10;
        run_txn(2'b10, 1'b1, 7'h50, 8'h77, 8'h3C, 1'b0, "read");
        req = 2'b00;
        tick();
        check_idle("read");
    endtask

    task automatic test_nack();
        int n;
        req_mode  = 2'b00;
        req_addr  = {7'h00, 7'h21};
        req_wdata = {8'h00, 8'h5A};
        m_out     = 8'hFF;
        req       = 2'b01;
        tick();
        tick();
        checks++;
        if (m_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL nack_start: got %b expected 1", m_start);
        end
        wait_done(100, n);
        checks++;
        if (n !== 64) begin
            errors++;
            $display("[TB] FAIL nack_latency: got %0d expected 64", n);
        end
        checks++;
        if ({done, err, rdata} !== {1'b1, 1'b1, 8'h3C}) begin
            errors++;
            $display("[TB] FAIL nack_done: got done/err/rdata=%b/%b/%h expected 1/1/3c", done, err, rdata);
        end
        req = 2'b00;
        tick();
        check_idle("nack");
    endtask

    task automatic test_contention();
        logic [1:0] exp;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        req_mode  = 2'b00;
        req_addr  = {7'h11, 7'h22};
        req_wdata = {8'hB1, 8'hB0};
        req       = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
            run_txn(exp, 1'b0, (k % 2 == 0) ? 7'h22 : 7'h11, (k % 2 == 0) ? 8'hB0 : 8'hB1,
                    8'h00, 1'b0, "contend");
            if (k == 3) req = 2'b00;
            tick();
            check_idle("contend");
        end
    endtask

    task automatic test_reset_mid();
        req_mode  = 2'b00;
        req_addr  = {7'h00, 7'h33};
        req_wdata = {8'h00, 8'hC3};
        req       = 2'b01;
        tick();
        tick();
        tick();
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({gnt, done, err, rdata, m_reset, m_en, m_start, m_stop, m_mode, m_address, m_register} !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got %h expected 00000000",
                     {gnt, done, err, rdata, m_reset, m_en, m_start, m_stop, m_mode, m_address, m_register});
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_done: got %b expected 0", done);
        end
        reset = 1'b1;
        run_txn(2'b01, 1'b0, 7'h33, 8'hC3, 8'h00, 1'b0, "after_reset");
        req = 2'b00;
        tick();
        check_idle("after_reset");
    endtask

    task automatic test_drop();
        req_mode  = 2'b00;
        req_addr  = {7'h00, 7'h0F};
        req_wdata = {8'h00, 8'hE1};
        req       = 2'b01;
        run_txn(2'b01, 1'b0, 7'h0F, 8'hE1, 8'h00, 1'b1, "drop");
        tick();
        check_idle("drop");
    endtask

    initial begin
        reset     = 1'b0;
        req       = 2'b00;
        req_mode  = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        m_ack     = 1'b0;
        m_out     = 8'h00;
        $display("[TB] starting i2c_txn_sequencer tests");
        test_reset();
        test_write();
        test_read();
        test_nack();
        test_contention();
        test_reset_mid();
        test_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
